// File: rtl/ex_div.sv
// EX-stage radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}, ready after W+1 edges.
module ex_div #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           signed_div_i,
  input  logic [W-1:0]   opdata1_i,
  input  logic [W-1:0]   opdata2_i,
  input  logic           start_i,
  input  logic           annul_i,
  output logic           busy_o,
  output logic [2*W-1:0] result_o,
  output logic           ready_o
);

  localparam logic [5:0] CNT_W = 6'(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2*W:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             rdy_q, rdy_d;

  logic [W:0]       diff;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;

  function automatic logic [W-1:0] mag(
    input logic [W-1:0] x,
    input logic         s
  );
    return (s && x[W-1]) ? -x : x;
  endfunction

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  // next-state, restoring step and result fix-up
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    // compare window sits one bit below the stored remainder,
    // so the subtract sees the bit the shift brings in
    diff = {1'b0, dvd_q[2*W-1:W]} - {1'b0, dvs_q};
    quo  = neg_q_q ? -dvd_q[W-1:0] : dvd_q[W-1:0];
    rem  = neg_r_q ? -dvd_q[2*W:W+1] : dvd_q[2*W:W+1];
    unique case (state_q)
      S_IDLE: begin
        res_d = '0;
        rdy_d = 1'b0;
        if (start_i && !annul_i) begin
          neg_q_d = signed_div_i
                  & (opdata1_i[W-1] ^ opdata2_i[W-1]);
          neg_r_d = signed_div_i & opdata1_i[W-1];
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            dvd_d   = {{W{1'b0}},
                       mag(opdata1_i, signed_div_i),
                       1'b0};
            dvs_d   = mag(opdata2_i, signed_div_i);
          end
        end
      end
      S_BYZERO: begin
        state_d = S_END;
        res_d   = '0;
        rdy_d   = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          res_d   = '0;
          rdy_d   = 1'b0;
        end else if (cnt_q != CNT_W) begin
          if (diff[W]) begin
            dvd_d = {dvd_q[2*W-1:0], 1'b0};
          end else begin
            dvd_d = {diff[W-1:0], dvd_q[W-1:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d = S_END;
          res_d   = {rem, quo};
          rdy_d   = 1'b1;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          res_d   = '0;
          rdy_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o   = (state_q == S_BYZERO) || (state_q == S_ON);
  assign result_o = res_q;
  assign ready_o  = rdy_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div.
// Scoreboard of expected results, checked on ready_o.
module tb_ex_div;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic           busy_o;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  ex_div #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .busy_o       (busy_o),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: truncating division, remainder follows dividend
  function automatic logic [63:0] model(
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return {32'd0, a};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic run_div(
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] res,
    input int          lat
  );
    exp_t e;
    int   n;
    logic got;
    sb.push_back('{res: res, lat: lat});
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_run", 64'(busy_o), 64'd1);
      if (ready_o) got = 1'b1;
    end
    e = sb.pop_front();
    check("done", 64'(got), 64'd1);
    check("latency", 64'(n - 1), 64'(e.lat));
    check("result", result_o, e.res);
    check("busy_end", 64'(busy_o), 64'd0);
    @(negedge clk);
    check("hold_rdy", 64'(ready_o), 64'd1);
    check("hold_res", result_o, e.res);
    start_i = 1'b0;
    @(negedge clk);
    check("clr_rdy", 64'(ready_o), 64'd0);
    check("clr_res", result_o, 64'd0);
    check("clr_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int   n;
    logic seen;
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_rdy", 64'(ready_o), 64'd0);
    check("rst_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 33);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2,
            64'hFFFFFFFF_FFFFFFFD, 33);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE,
            64'h00000001_FFFFFFFD, 33);
    run_div(1'b0, 32'd5, 32'd0, 64'd0, 1);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            64'h00000000_80000000, 33);
    run_div(1'b0, 32'd0, 32'd5, 64'd0, 33);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10,
            model(1'b0, 32'hFFFF_FFFF, 32'h10), 33);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7,
            model(1'b1, 32'hFFFF_FF9C, 32'd7), 33);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
            model(1'b0, 32'h8000_0000, 32'hFFFF_FFFF), 33);
    run_div(1'b1, 32'd5, 32'd0, 64'd0, 1);

    // start with annul in IDLE is not accepted
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    repeat (3) @(negedge clk);
    check("annul_idle_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);

    // annul mid-operation at cnt=10
    start_i = 1'b1;
    repeat (11) @(negedge clk);
    check("pre_annul_busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    check("annul_no_rdy", 64'(seen), 64'd0);
    run_div(1'b0, 32'd9, 32'd3,
            64'h00000000_00000003, 33);

    // async reset mid-ON, between edges
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_rdy", 64'(ready_o), 64'd0);
    check("arst_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div(1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 33);

    // async reset while holding a result in END
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("end_rdy", 64'(ready_o), 64'd1);
    check("end_res", result_o, 64'h00000000_00000003);
    #2;
    rst = 1'b0;
    #1;
    check("arst_end_rdy", 64'(ready_o), 64'd0);
    check("arst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
